// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master shift engine: FSM states,
// word-size codes and the bit-order aware shift helpers.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSON,
        ST_LOAD,
        ST_SHIFT,
        ST_PUSH,
        ST_CSOFF
    } spi_state_e;

    localparam logic [1:0] SPI_TRANS_8_BITS  = 2'd0;
    localparam logic [1:0] SPI_TRANS_16_BITS = 2'd1;
    localparam logic [1:0] SPI_TRANS_24_BITS = 2'd2;
    localparam logic [1:0] SPI_TRANS_32_BITS = 2'd3;

    function automatic logic [5:0] spi_bits(input logic [1:0] dsize);
        logic [5:0] n;
        case (dsize)
            SPI_TRANS_8_BITS:  n = 6'd8;
            SPI_TRANS_16_BITS: n = 6'd16;
            SPI_TRANS_24_BITS: n = 6'd24;
            SPI_TRANS_32_BITS: n = 6'd32;
            default:           n = 6'd32;
        endcase
        return n;
    endfunction

    // The shift register is pre-aligned so the next bit to send always sits
    // at bit 31 (MSB-first) or bit 0 (LSB-first).
    function automatic logic spi_head(input logic [31:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[31];
    endfunction

    function automatic logic [31:0] spi_advance(input logic [31:0] sr, input logic lsb);
        return lsb ? {1'b0, sr[31:1]} : {sr[30:0], 1'b0};
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK divider: while enabled, emits alternating leading/trailing edge pulses
// every div_i+1 cycles and tracks the SCK phase (0 = idle level).
module spi_clkgen (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [7:0] div_i,
    output logic       lead_o,
    output logic       trail_o,
    output logic       tog_o
);

    logic [7:0] cnt_q;
    logic       tog_q;
    logic       edge_w;

    assign edge_w  = en_i && (cnt_q == 8'd0);
    assign lead_o  = edge_w && !tog_q;
    assign trail_o = edge_w && tog_q;
    assign tog_o   = tog_q;

    // Held in reload while disabled so every enable starts a full half-period.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 8'd0;
            tog_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= div_i;
            tog_q <= 1'b0;
        end else if (cnt_q == 8'd0) begin
            cnt_q <= div_i;
            tog_q <= ~tog_q;
        end else begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Standard-mode SPI master: pops TX FIFO words, serialises them with the
// latched CPOL/CPHA/order/size, pushes received words and frames chip select.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [7:0]           div_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic                 lsb_i,
    input  logic [1:0]           dsize_i,
    input  logic [CNT_WIDTH-1:0] trl_i,
    input  logic                 ass_i,
    input  logic [3:0]           nss_i,
    input  logic [3:0]           csv_i,
    output logic                 busy_o,
    output logic                 last_o,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [31:0]          tx_data_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [31:0]          rx_data_o,
    output logic                 spi_sck_o,
    output logic [3:0]           spi_nss_o,
    output logic                 spi_mosi_o,
    input  logic                 spi_miso_i
);

    spi_state_e           state_q;
    logic                 busy_q, last_q, tx_ready_q, rx_valid_q, mosi_q;
    logic                 cpol_q, cpha_q, lsb_q;
    logic [1:0]           dsize_q;
    logic [7:0]           div_q, wait_q;
    logic [3:0]           nss_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [5:0]           bit_q;
    logic [31:0]          tx_sr_q, rx_sr_q, rx_data_q;

    logic        lead, trail, tog, out_edge, smp_edge;
    logic [5:0]  nbits;
    logic [31:0] tx_aligned;

    spi_clkgen u_clkgen (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == ST_SHIFT),
        .div_i   (div_q),
        .lead_o  (lead),
        .trail_o (trail),
        .tog_o   (tog)
    );

    assign nbits      = spi_bits(dsize_q);
    assign tx_aligned = lsb_q ? tx_data_i : (tx_data_i << (6'd32 - nbits));
    assign out_edge   = cpha_q ? lead : trail;
    assign smp_edge   = cpha_q ? trail : lead;

    assign busy_o     = busy_q;
    assign last_o     = last_q;
    assign tx_ready_o = tx_ready_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign spi_mosi_o = mosi_q;
    assign spi_sck_o  = (state_q == ST_IDLE) ? cpol_i : (cpol_q ^ tog);
    assign spi_nss_o  = ass_i ? nss_q : csv_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            dsize_q    <= SPI_TRANS_8_BITS;
            div_q      <= 8'd0;
            wait_q     <= 8'd0;
            nss_q      <= 4'hF;
            cnt_q      <= '0;
            bit_q      <= 6'd0;
            tx_sr_q    <= 32'd0;
            rx_sr_q    <= 32'd0;
            rx_data_q  <= 32'd0;
        end else begin
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            case (state_q)
                ST_IDLE: if (start_i) begin
                    state_q <= ST_CSON;
                    busy_q  <= 1'b1;
                    cpol_q  <= cpol_i;
                    cpha_q  <= cpha_i;
                    lsb_q   <= lsb_i;
                    dsize_q <= dsize_i;
                    div_q   <= div_i;
                    wait_q  <= div_i;
                    nss_q   <= ~nss_i;
                    cnt_q   <= (trl_i == '0) ? CNT_WIDTH'(1) : trl_i;
                end
                ST_CSON: begin
                    if (wait_q == 8'd0) state_q <= ST_LOAD;
                    else                wait_q  <= wait_q - 8'd1;
                end
                ST_LOAD: if (tx_valid_i) begin
                    tx_ready_q <= 1'b1;
                    rx_sr_q    <= 32'd0;
                    bit_q      <= 6'd0;
                    state_q    <= ST_SHIFT;
                    // CPHA=0 needs the first bit on MOSI before the first edge.
                    if (cpha_q) begin
                        tx_sr_q <= tx_aligned;
                    end else begin
                        mosi_q  <= spi_head(tx_aligned, lsb_q);
                        tx_sr_q <= spi_advance(tx_aligned, lsb_q);
                    end
                end
                ST_SHIFT: begin
                    if (out_edge) begin
                        mosi_q  <= spi_head(tx_sr_q, lsb_q);
                        tx_sr_q <= spi_advance(tx_sr_q, lsb_q);
                    end
                    if (smp_edge)
                        rx_sr_q <= lsb_q ? {spi_miso_i, rx_sr_q[31:1]} : {rx_sr_q[30:0], spi_miso_i};
                    if (trail) begin
                        bit_q <= bit_q + 6'd1;
                        if (bit_q == nbits - 6'd1) state_q <= ST_PUSH;
                    end
                end
                ST_PUSH: if (rx_ready_i) begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= lsb_q ? (rx_sr_q >> (6'd32 - nbits)) : rx_sr_q;
                    cnt_q      <= cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_q <= ST_CSOFF;
                        wait_q  <= div_q;
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_CSOFF: begin
                    // Hold CS a half-period, then one final busy cycle with CS released.
                    if (wait_q != 8'd0) begin
                        wait_q <= wait_q - 8'd1;
                    end else if (!last_q) begin
                        nss_q  <= 4'hF;
                        last_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: MISO looped back to MOSI, TX/RX FIFOs
// modelled by a word table and monitors sampling on the falling clock edge.
module tb_spi_shift_engine;

    logic        clk = 1'b0;
    logic        rst_n_i, start_i, cpol_i, cpha_i, lsb_i, ass_i;
    logic [7:0]  div_i;
    logic [1:0]  dsize_i;
    logic [15:0] trl_i;
    logic [3:0]  nss_i, csv_i;
    logic        busy_o, last_o, tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
    logic [31:0] tx_data_i, rx_data_o;
    logic        spi_sck_o, spi_mosi_o, spi_miso_i;
    logic [3:0]  spi_nss_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] tx_words [4];
    logic [31:0] rx_got [4];
    int tx_idx, tx_num;
    int n_pop, n_push, n_last, last_at_push, n_lead, n_trail, n_cs_bad;
    int gap, hp_min, hp_max;
    logic [31:0] mosi_log;
    logic sck_prev;

    always #5 clk = ~clk;

    spi_shift_engine #(.CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .div_i(div_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_i(lsb_i), .dsize_i(dsize_i),
        .trl_i(trl_i), .ass_i(ass_i), .nss_i(nss_i), .csv_i(csv_i),
        .busy_o(busy_o), .last_o(last_o), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o), .spi_sck_o(spi_sck_o),
        .spi_nss_o(spi_nss_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i)
    );

    assign spi_miso_i = spi_mosi_o;

    always_comb begin
        tx_valid_i = (tx_idx < tx_num) && (tx_idx < 4);
        tx_data_i  = tx_words[tx_idx[1:0]];
    end

    always @(negedge clk) begin
        if (tx_ready_o === 1'b1) begin n_pop++; tx_idx++; end
        if (rx_valid_o === 1'b1) begin
            if (n_push < 4) rx_got[n_push[1:0]] = rx_data_o;
            n_push++;
        end
        if (last_o === 1'b1) begin n_last++; last_at_push = n_push; end
        if (spi_sck_o !== sck_prev && busy_o === 1'b1) begin
            if (n_lead + n_trail > 0) begin
                if (gap + 1 < hp_min) hp_min = gap + 1;
                if (gap + 1 > hp_max) hp_max = gap + 1;
            end
            gap = 0;
            if (spi_sck_o !== cpol_i) n_lead++; else n_trail++;
            if (spi_sck_o === (cpha_i ? cpol_i : ~cpol_i)) mosi_log = {mosi_log[30:0], spi_mosi_o};
        end else begin
            gap++;
        end
        sck_prev = spi_sck_o;
        if (!ass_i) begin
            if (spi_nss_o !== csv_i) n_cs_bad++;
        end else if (busy_o === 1'b1 && last_o !== 1'b1) begin
            if (spi_nss_o !== ~nss_i) n_cs_bad++;
        end else if (spi_nss_o !== 4'hF) begin
            n_cs_bad++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_pop = 0; n_push = 0; n_last = 0; last_at_push = -1;
        n_lead = 0; n_trail = 0; n_cs_bad = 0;
        gap = 0; hp_min = 999; hp_max = 0; mosi_log = 32'd0;
        tx_idx = 0;
        for (int i = 0; i < 4; i++) rx_got[i] = 32'hDEAD_BEEF;
    endtask

    task automatic cfg(input logic pol, input logic pha, input logic lsb,
                       input logic [1:0] ds, input logic [7:0] dv, input logic [15:0] trl);
        cpol_i = pol; cpha_i = pha; lsb_i = lsb; dsize_i = ds; div_i = dv; trl_i = trl;
        tick();
        clr();
    endtask

    task automatic start_xfer();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o === 1'b1 && n < 5000) begin tick(); n++; end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    task automatic wait_pushes(input string tag, input int k);
        int n = 0;
        while (n_push < k && n < 5000) begin tick(); n++; end
        chk(tag, 32'(n_push >= k), 32'd1);
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; ass_i = 1'b1; nss_i = 4'b0001; csv_i = 4'b1010;
        rx_ready_i = 1'b1; tx_num = 0; sck_prev = 1'b0;
        for (int i = 0; i < 4; i++) tx_words[i] = 32'd0;
        cfg(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 16'd1);
        repeat (2) tick();

        // Reset values
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_txrdy", 32'(tx_ready_o), 32'd0);
        chk("rst_rxvld", 32'(rx_valid_o), 32'd0);
        chk("rst_rxdata", rx_data_o, 32'd0);
        chk("rst_mosi", 32'(spi_mosi_o), 32'd0);
        chk("rst_nss", 32'(spi_nss_o), 32'hF);
        chk("rst_sck0", 32'(spi_sck_o), 32'd0);
        cpol_i = 1'b1; #1;
        chk("rst_sck1", 32'(spi_sck_o), 32'd1);
        cpol_i = 1'b0;
        rst_n_i = 1'b1;
        tick();

        // Mode 0, div 0, 8-bit, one word 0xA5
        cfg(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 16'd1);
        tx_words[0] = 32'h0000_00A5; tx_num = 1;
        start_xfer();
        wait_idle("m0_done");
        chk("m0_mosi", mosi_log, 32'h0000_00A5);
        chk("m0_rx", rx_got[0], 32'h0000_00A5);
        chk("m0_pop", 32'(n_pop), 32'd1);
        chk("m0_push", 32'(n_push), 32'd1);
        chk("m0_last", 32'(n_last), 32'd1);
        chk("m0_lead", 32'(n_lead), 32'd8);
        chk("m0_hpmin", 32'(hp_min), 32'd1);
        chk("m0_hpmax", 32'(hp_max), 32'd1);
        chk("m0_cs", 32'(n_cs_bad), 32'd0);

        // Mode 3, div 3, 32-bit LSB-first
        cfg(1'b1, 1'b1, 1'b1, 2'd3, 8'd3, 16'd1);
        tx_words[0] = 32'h1234_5678; tx_num = 1;
        start_xfer();
        wait_idle("m3_done");
        chk("m3_mosi", mosi_log, 32'h1E6A_2C48);
        chk("m3_rx", rx_got[0], 32'h1234_5678);
        chk("m3_lead", 32'(n_lead), 32'd32);
        chk("m3_trail", 32'(n_trail), 32'd32);
        chk("m3_hpmin", 32'(hp_min), 32'd4);
        chk("m3_hpmax", 32'(hp_max), 32'd4);
        chk("m3_sckidle", 32'(spi_sck_o), 32'd1);
        chk("m3_cs", 32'(n_cs_bad), 32'd0);

        // Three words with the TX FIFO empty after the first
        cfg(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 16'd3);
        tx_words[0] = 32'h11; tx_words[1] = 32'h22; tx_words[2] = 32'h33; tx_num = 1;
        start_xfer();
        begin
            int n = 0;
            while (n_pop < 1 && n < 200) begin tick(); n++; end
        end
        repeat (25) tick();
        begin
            int e0;
            e0 = n_lead + n_trail;
            chk("txs_push1", 32'(n_push), 32'd1);
            repeat (10) tick();
            chk("txs_noedge", 32'(n_lead + n_trail), 32'(e0));
        end
        chk("txs_sck", 32'(spi_sck_o), 32'd0);
        chk("txs_busy", 32'(busy_o), 32'd1);
        chk("txs_pop", 32'(n_pop), 32'd1);
        tx_num = 3;
        wait_idle("txs_done");
        chk("txs_push", 32'(n_push), 32'd3);
        chk("txs_rx0", rx_got[0], 32'h11);
        chk("txs_rx1", rx_got[1], 32'h22);
        chk("txs_rx2", rx_got[2], 32'h33);
        chk("txs_last", 32'(n_last), 32'd1);
        chk("txs_lastpos", 32'(last_at_push), 32'd3);
        chk("txs_cs", 32'(n_cs_bad), 32'd0);

        // RX FIFO full while the second word waits to be pushed (mode 2)
        cfg(1'b1, 1'b0, 1'b0, 2'd0, 8'd1, 16'd3);
        tx_words[0] = 32'hC3; tx_words[1] = 32'h3C; tx_words[2] = 32'h81; tx_num = 3;
        start_xfer();
        wait_pushes("rxs_push1", 1);
        rx_ready_i = 1'b0;
        repeat (60) tick();
        chk("rxs_pop_held", 32'(n_pop), 32'd2);
        chk("rxs_push_held", 32'(n_push), 32'd1);
        chk("rxs_busy", 32'(busy_o), 32'd1);
        rx_ready_i = 1'b1;
        wait_idle("rxs_done");
        chk("rxs_pop", 32'(n_pop), 32'd3);
        chk("rxs_rx0", rx_got[0], 32'hC3);
        chk("rxs_rx1", rx_got[1], 32'h3C);
        chk("rxs_rx2", rx_got[2], 32'h81);
        chk("rxs_sckidle", 32'(spi_sck_o), 32'd1);

        // trl=0 behaves as one word; manual chip select; 24-bit with junk upper byte
        ass_i = 1'b0;
        cfg(1'b0, 1'b1, 1'b0, 2'd2, 8'd2, 16'd0);
        tx_words[0] = 32'hFFAB_CDEF; tx_words[1] = 32'h0000_0055; tx_num = 2;
        start_xfer();
        wait_idle("trl0_done");
        chk("trl0_pop", 32'(n_pop), 32'd1);
        chk("trl0_push", 32'(n_push), 32'd1);
        chk("trl0_rx", rx_got[0], 32'h00AB_CDEF);
        chk("trl0_mosi", mosi_log & 32'h00FF_FFFF, 32'h00AB_CDEF);
        chk("trl0_lead", 32'(n_lead), 32'd24);
        chk("trl0_csv", 32'(n_cs_bad), 32'd0);
        ass_i = 1'b1;

        // Reset in the middle of the second word
        cfg(1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 16'd2);
        tx_words[0] = 32'h5A; tx_words[1] = 32'h96; tx_num = 2;
        start_xfer();
        wait_pushes("mrst_push1", 1);
        repeat (10) tick();
        rst_n_i = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_nss", 32'(spi_nss_o), 32'hF);
        chk("mrst_sck", 32'(spi_sck_o), 32'd0);
        chk("mrst_rxdata", rx_data_o, 32'd0);
        chk("mrst_rxvld", 32'(rx_valid_o), 32'd0);
        repeat (3) tick();
        chk("mrst_nopush", 32'(n_push), 32'd1);
        rst_n_i = 1'b1;
        cfg(1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 16'd1);
        tx_words[0] = 32'h3C; tx_num = 1;
        start_xfer();
        wait_idle("mrst_redo");
        chk("mrst_rx", rx_got[0], 32'h3C);
        chk("mrst_push", 32'(n_push), 32'd1);
        chk("mrst_last", 32'(n_last), 32'd1);
        chk("mrst_cs", 32'(n_cs_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
